// File: rtl/gnn_mac_sched.sv
// Purpose : one dense GNN layer H[n][j] = sum_i X[n][i]*W[i][j] on a single shared signed MAC.
// Latency : first result FEAT edges after capture; one result every FEAT+1 cycles with res_ready=1.
// Backpressure: a pending result is held stable and the MAC stalls until res_ready; abort flushes to IDLE.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid / in_ready    operand capture handshake (ready only in IDLE)
//   x_flat, w_flat         packed signed X[n][i] and W[i][j] operand matrices
//   abort                  synchronous flush of a running layer
//   res_valid / res_ready  result handshake; res_data/res_node/res_col/res_last describe the element
//   busy, done             running flag, one-cycle pulse after the final element is accepted
module gnn_mac_sched #(
   parameter int NODES = 4,
   parameter int FEAT  = 4,
   parameter int OUTF  = 4,
   parameter int DW    = 5,
   parameter int ACC_W = 12
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NODES*FEAT*DW-1:0]  x_flat,
   input  logic [FEAT*OUTF*DW-1:0]   w_flat,
   input  logic                      abort,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [ACC_W-1:0]          res_data,
   output logic [$clog2(NODES)-1:0]  res_node,
   output logic [$clog2(OUTF)-1:0]   res_col,
   output logic                      res_last,
   output logic                      busy,
   output logic                      done
);

   localparam int NW = $clog2(NODES);
   localparam int JW = $clog2(OUTF);
   localparam int IW = $clog2(FEAT);
   localparam logic [NW-1:0] N_LAST = NW'(NODES-1);
   localparam logic [JW-1:0] J_LAST = JW'(OUTF-1);
   localparam logic [IW-1:0] I_LAST = IW'(FEAT-1);

   typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

   state_t                   r_state;
   logic [NODES*FEAT*DW-1:0] r_x;
   logic [FEAT*OUTF*DW-1:0]  r_w;
   logic [NW-1:0]            r_n;
   logic [JW-1:0]            r_j;
   logic [IW-1:0]            r_i;
   logic [ACC_W-1:0]         r_acc;
   logic                     r_res_valid;
   logic [ACC_W-1:0]         r_res_data;
   logic [NW-1:0]            r_res_node;
   logic [JW-1:0]            r_res_col;
   logic                     r_res_last;
   logic                     r_done;

   // Unpacked views of the captured operands so the MAC can index by counters.
   logic [DW-1:0] w_x [NODES][FEAT];
   logic [DW-1:0] w_w [FEAT][OUTF];

   for (genvar gn = 0; gn < NODES; gn++) begin : g_xn
      for (genvar gi = 0; gi < FEAT; gi++) begin : g_xi
         assign w_x[gn][gi] = r_x[(gn*FEAT+gi)*DW +: DW];
      end
   end
   for (genvar gi = 0; gi < FEAT; gi++) begin : g_wi
      for (genvar gj = 0; gj < OUTF; gj++) begin : g_wj
         assign w_w[gi][gj] = r_w[(gi*OUTF+gj)*DW +: DW];
      end
   end

   logic [DW-1:0]    w_xs;
   logic [DW-1:0]    w_ws;
   logic [2*DW-1:0]  w_prod;
   logic [ACC_W-1:0] w_sum;

   assign w_xs = w_x[r_n][r_i];
   assign w_ws = w_w[r_i][r_j];
   // Both operands sign-extended to 2*DW first: the low 2*DW bits of the
   // unsigned product are then the exact two's-complement signed product.
   assign w_prod = {{DW{w_xs[DW-1]}}, w_xs} * {{DW{w_ws[DW-1]}}, w_ws};
   assign w_sum  = r_acc + {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_x         <= '0;
         r_w         <= '0;
         r_n         <= '0;
         r_j         <= '0;
         r_i         <= '0;
         r_acc       <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_node  <= '0;
         r_res_col   <= '0;
         r_res_last  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               // abort has no meaning here and must not block a capture.
               if (in_valid) begin
                  r_x     <= x_flat;
                  r_w     <= w_flat;
                  r_n     <= '0;
                  r_j     <= '0;
                  r_i     <= '0;
                  r_acc   <= '0;
                  r_state <= MAC;
               end
            end
            MAC: begin
               if (abort) begin
                  r_state     <= IDLE;
                  r_res_valid <= 1'b0;
                  r_res_last  <= 1'b0;
                  r_acc       <= '0;
                  r_i         <= '0;
               end else if (r_i == I_LAST) begin
                  r_acc       <= w_sum;
                  r_res_data  <= w_sum;
                  r_res_node  <= r_n;
                  r_res_col   <= r_j;
                  r_res_last  <= (r_n == N_LAST) && (r_j == J_LAST);
                  r_res_valid <= 1'b1;
                  r_state     <= EMIT;
               end else begin
                  r_acc <= w_sum;
                  r_i   <= r_i + IW'(1);
               end
            end
            EMIT: begin
               // abort wins over a coincident handshake.
               if (abort) begin
                  r_state     <= IDLE;
                  r_res_valid <= 1'b0;
                  r_res_last  <= 1'b0;
                  r_acc       <= '0;
                  r_i         <= '0;
               end else if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_acc       <= '0;
                  r_i         <= '0;
                  if (r_res_last) begin
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     if (r_j == J_LAST) begin
                        r_j <= '0;
                        r_n <= r_n + NW'(1);
                     end else begin
                        r_j <= r_j + JW'(1);
                     end
                     r_state <= MAC;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign res_node  = r_res_node;
   assign res_col   = r_res_col;
   assign res_last  = r_res_last;
   assign done      = r_done;

endmodule

// File: tb/tb_gnn_mac_sched.sv
module tb_gnn_mac_sched;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [79:0] x_flat;
   logic [79:0] w_flat;
   logic        abort;
   logic        res_valid;
   logic        res_ready;
   logic [11:0] res_data;
   logic [1:0]  res_node;
   logic [1:0]  res_col;
   logic        res_last;
   logic        busy;
   logic        done;

   gnn_mac_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_flat    (x_flat),
      .w_flat    (w_flat),
      .abort     (abort),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_node  (res_node),
      .res_col   (res_col),
      .res_last  (res_last),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   int cap_cyc  = 0;

   // Reference: plain integer matrices and the matrix product.
   int X [4][4];
   int W [4][4];
   int H [4][4];

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int rnd5();
      return int'($urandom_range(0, 31)) - 16;
   endfunction

   task automatic fill(input bit rand_ops, input int xv, input int wv);
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++) begin
            X[a][b] = rand_ops ? rnd5() : xv;
            W[a][b] = rand_ops ? rnd5() : wv;
         end
   endtask

   // Drive operands, perform the capture handshake, then scramble the inputs
   // so any late re-sampling of x_flat/w_flat shows up as wrong results.
   task automatic capture(input bit with_abort);
      for (int n = 0; n < 4; n++)
         for (int j = 0; j < 4; j++) begin
            H[n][j] = 0;
            for (int i = 0; i < 4; i++) H[n][j] += X[n][i] * W[i][j];
         end
      @(negedge clk);
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++) begin
            x_flat[(a*4+b)*5 +: 5] = 5'(X[a][b]);
            w_flat[(a*4+b)*5 +: 5] = 5'(W[a][b]);
         end
      check("in_ready_before_capture", int'(in_ready), 1);
      in_valid = 1'b1;
      abort    = with_abort;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      abort    = 1'b0;
      cap_cyc  = cyc;
      x_flat   = {$urandom, $urandom, $urandom};
      w_flat   = {$urandom, $urandom, $urandom};
      check("busy_after_capture", int'(busy), 1);
   endtask

   // Accept n_res results in node-major order, optionally stalling one of them.
   task automatic collect(input int n_res, input int stall_k, input int stall_len);
      int rdy_hi;
      int en;
      int ej;
      rdy_hi = 0;
      for (int k = 0; k < n_res; k++) begin
         en = k / 4;
         ej = k % 4;
         for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (in_ready) rdy_hi++;
            if (res_valid) break;
         end
         if (!res_valid) begin
            check("res_valid_timeout", 0, 1);
            return;
         end
         if (k == 0) check("first_result_latency", cyc - cap_cyc, 4);
         check("res_data", int'($signed(res_data)), H[en][ej]);
         check("res_node", int'(res_node), en);
         check("res_col", int'(res_col), ej);
         check("res_last", int'(res_last), (k == 15) ? 1 : 0);
         if (k == stall_k) begin
            res_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               @(negedge clk);
               check("stall_valid", int'(res_valid), 1);
               check("stall_data", int'($signed(res_data)), H[en][ej]);
               check("stall_node", int'(res_node), en);
               check("stall_col", int'(res_col), ej);
            end
            res_ready = 1'b1;
         end
         @(negedge clk);
         check("valid_dropped_after_hs", int'(res_valid), 0);
         if (k == 15) begin
            check("total_run_cycles", cyc - cap_cyc, 80 + stall_len);
            check("done_pulse", int'(done), 1);
            check("idle_after_done", int'(busy), 0);
            check("in_ready_low_during_run", rdy_hi, 0);
            @(negedge clk);
            check("done_one_cycle", int'(done), 0);
         end else if (k != n_res - 1) begin
            check("done_not_early", int'(done), 0);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dn;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      abort     = 1'b0;
      res_ready = 1'b1;
      x_flat    = '0;
      w_flat    = '0;
      #12;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_res_valid", int'(res_valid), 0);
      check("rst_res_data", int'(res_data), 0);
      check("rst_res_node", int'(res_node), 0);
      check("rst_res_col", int'(res_col), 0);
      check("rst_res_last", int'(res_last), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Most negative operands everywhere: each element is 4*256.
      fill(1'b0, -16, -16);
      capture(1'b0);
      collect(16, -1, 0);

      // Most positive operands: each element is 4*225.
      fill(1'b0, 15, 15);
      capture(1'b0);
      collect(16, -1, 0);

      // Mixed operands with directed rows 0 and 2 and column 0.
      fill(1'b1, 0, 0);
      X[0][0] = 4; X[0][1] = 2; X[0][2] = 4; X[0][3] = 1;
      X[2][0] = 8; X[2][1] = 6; X[2][2] = 4; X[2][3] = 1;
      W[0][0] = 3; W[1][0] = 2; W[2][0] = 13; W[3][0] = -6;
      capture(1'b0);
      collect(16, -1, 0);

      // Backpressure on the third result for 5 cycles.
      fill(1'b1, 0, 0);
      capture(1'b0);
      collect(16, 2, 5);

      // Abort during the MAC of element (1,2).
      fill(1'b1, 0, 0);
      capture(1'b0);
      collect(6, -1, 0);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_res_valid", int'(res_valid), 0);
      check("abort_res_last", int'(res_last), 0);
      check("abort_in_ready", int'(in_ready), 1);
      dn = 0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (done || res_valid) dn++;
      end
      check("abort_no_done_or_result", dn, 0);

      // Restart, with abort coincident with the capture in IDLE.
      fill(1'b1, 0, 0);
      capture(1'b1);
      collect(16, -1, 0);

      // Reset mid-EMIT while the result is stalled.
      fill(1'b1, 0, 0);
      capture(1'b0);
      collect(3, -1, 0);
      res_ready = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (res_valid) break;
      end
      check("pre_reset_valid", int'(res_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_res_valid", int'(res_valid), 0);
      check("arst_res_data", int'(res_data), 0);
      check("arst_res_node", int'(res_node), 0);
      check("arst_res_col", int'(res_col), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_in_ready", int'(in_ready), 1);
      @(negedge clk);
      rst_n     = 1'b1;
      res_ready = 1'b1;
      dn = 0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (res_valid || busy || done) dn++;
      end
      check("post_reset_quiet", dn, 0);
      fill(1'b1, 0, 0);
      capture(1'b0);
      collect(16, -1, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
